expr_eval: RTL and testbench
============================

# expr_eval

Arithmetic evaluator that sits directly downstream of the `expr` recognizer and consumes the same ASCII character stream, one character per accepted clock. It parses single-digit expressions of the form `d (op d)*` with `op` ∈ {`+`, `*`} and standard precedence (`*` binds tighter than `+`). It maintains a running value, a well-formed flag and sticky error and overflow flags. Its output feeds the display/result stage.

## Interface
- `WIDTH`, default 16: width of the value, sum and term registers; minimum 4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, synchronous and active-high; one clock; returns the block to its reset state.
- `in`  in  8  ASCII character; sampled only when `in_valid` is 1.
- `in_valid`  in  1  character strobe; when 0 the block holds all state.
- `value`  out  WIDTH  result of the expression so far, modulo 2^WIDTH.
- `ok`  out  1  1 when the accepted prefix is a complete well-formed expression.
- `err`  out  1  sticky syntax error.
- `ovf`  out  1  sticky arithmetic overflow (see Configuration).

## Operation
- State machine with four states:
  - `S_START` expects a digit (reset state).
  - `S_NUM` follows a digit; the expression is complete.
  - `S_OP` follows an operator and expects a digit.
  - `S_ERR` is absorbing; only `clr` leaves it.
- Internal registers: `sum` (WIDTH), `term` (WIDTH), `last_op` (1 bit: add or mul).
- Character classes:
  - Digits are `"0"`–`"9"` (0x30–0x39), with d = in − 0x30.
  - Operators are `"+"` (0x2B) and `"*"` (0x2A).
  - Everything else is illegal.
- Transitions on an accepted character:
  - `S_START` + digit: term←d, sum←0, go to `S_NUM`.
  - `S_NUM` + `+`: sum←sum+term, last_op←add, go to `S_OP`.
  - `S_NUM` + `*`: last_op←mul, go to `S_OP`.
  - `S_OP` + digit:
    - If last_op is add: term←d.
    - If last_op is mul: term←term·d (low WIDTH bits).
    - Go to `S_NUM`.
  - Any other combination, including an illegal character: go to `S_ERR`.
- Outputs:
  - `value` is updated only on entry to `S_NUM`, to (new sum + new term) mod 2^WIDTH. Otherwise it holds.
  - `ok` is 1 exactly when the state is `S_NUM`.
  - `err` is 1 exactly when the state is `S_ERR`.
  - In `S_ERR`, `value` freezes at its last value and `ovf` freezes.
- Arithmetic:
  - All arithmetic is unsigned and wraps modulo 2^WIDTH.
  - The product is computed at WIDTH+4 bits, then truncated to WIDTH.
  - Sums are computed at WIDTH+1 bits, then truncated to WIDTH.

## Timing
- All outputs are registered.
- A character sampled at edge N is reflected in `value`, `ok`, `err` and `ovf` immediately after edge N. There are no pipeline bubbles.
- Throughput is one character per cycle with `in_valid` held high.
- When `in_valid` is 0, nothing changes, including in `S_ERR`.
- Reset:
  - `clr`=1 at an edge forces state to `S_START` and sets sum=term=value=0 and ok=err=ovf=0.
  - `clr` has priority over a simultaneous `in_valid`; that character is dropped.
  - `clr` asserted mid-expression discards the partial result; the next character starts a fresh expression.
- The `ok` and `err` flags of this block match the `out` of `expr` on the same accepted stream.

## Configuration
- Macro: `EXPR_EVAL_OVF_EN`.
- Defined:
  - `ovf` sets when any add or multiply result exceeds 2^WIDTH−1 before truncation. This covers sum+term in `S_NUM`→`S_OP`, term·d, and the value computation.
  - `ovf` is sticky until `clr`.
- Not defined:
  - `ovf` is tied to 0 and the widened carry/product bits are not generated.
  - Wrapping behaviour of `value` is identical in both builds.

## Structure
- Shared package `expr_pkg` holds:
  - the state encoding (`S_START`, `S_NUM`, `S_OP`, `S_ERR`), also used by `expr`;
  - ASCII constants `CH_0`, `CH_9`, `CH_PLUS`, `CH_MUL`;
  - the `last_op` encoding.
- One combinational sub-module, `ascii_class`. It maps `in` to {is_digit, is_plus, is_mul, digit[3:0]} and is shared with `expr`.
- Everything else stays in one `expr_eval` module.

## Test plan
- Precedence: stream `"1+2*3"` with `in_valid`=1 -> after the 5th edge value=7, ok=1, err=0. `ok` toggles 1,0,1,0,1 across the five edges.
- Mixed expression: `"2*3+4*5"` -> value=26, ok=1. After `"2*3+"` value=6, ok=0.
- Syntax error: `"1++2"` -> err=1 from the 3rd edge, ok=0, value holds 1. `"2"` afterwards leaves err=1 and value=1.
- Overflow: WIDTH=8, `"9*9*9"` -> value=217 (729 mod 256), ok=1. ovf=1 with `EXPR_EVAL_OVF_EN` defined and 0 without it. `"9*9"` -> value=81, ovf=0.
- Stalls: `"4"`, `in_valid`=0 for 3 cycles (with `in` driven to `"+"`), then `"+5"` -> value stays 4 during the stall and is 9 at the end.
- Reset mid-stream: `"5*"`, then `clr`=1 with `in_valid`=1 and `in`=`"7"`, then `"3"` -> after the `clr` edge all outputs are 0. Final value=3, ok=1, ovf=0.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared definitions for the expression recognizer (expr) and evaluator
// (expr_eval): parser state encoding, ASCII constants and operator encoding.
package expr_pkg;

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_NUM   = 2'd1,
      S_OP    = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_MUL = 1'b1
   } op_t;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_MUL  = 8'h2A;

endpackage

// File: rtl/expr_eval_ascii_class.sv
// ascii_class: combinational character classifier shared by expr and
// expr_eval. Splits an ASCII byte into digit / '+' / '*' classes and the
// digit value.
module ascii_class
   import expr_pkg::*;
(
   input  logic [7:0] in,
   output logic       is_digit,
   output logic       is_plus,
   output logic       is_mul,
   output logic [3:0] digit
);

   // Classify the character; digit value is only meaningful when is_digit.
   always_comb begin
      is_digit = (in >= CH_0) && (in <= CH_9);
      is_plus  = (in == CH_PLUS);
      is_mul   = (in == CH_MUL);
      // '0'..'9' are 0x30..0x39, so subtracting 0x30 leaves the low nibble.
      digit    = in[3:0];
   end

endmodule

// File: rtl/expr_eval.sv
// expr_eval: single-digit '+'/'*' expression evaluator with precedence.
// Build option: define EXPR_EVAL_OVF_EN to enable the sticky overflow flag;
// without it ovf is constant 0 and no widened carry/product bits exist.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_START | expecting the first digit (reset state)
// S_NUM   | just took a digit; prefix is a complete expression
// S_OP    | just took an operator; expecting a digit
// S_ERR   | syntax error seen; absorbing until clr
module expr_eval
   import expr_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] value,
   output logic             ok,
   output logic             err,
   output logic             ovf
);

   state_t           state;
   state_t           nxt_state;
   op_t              last_op;
   op_t              nxt_op;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] nxt_sum;
   logic [WIDTH-1:0] nxt_term;
   logic             load_value;
   logic             ovf_set;

   logic             is_digit;
   logic             is_plus;
   logic             is_mul;
   logic [3:0]       digit;
   logic [WIDTH-1:0] digit_w;

   logic [WIDTH-1:0] sum_add;
   logic [WIDTH-1:0] prod;
   logic [WIDTH-1:0] value_nxt;
   logic             sum_carry;
   logic             prod_carry;
   logic             value_carry;

   ascii_class u_class (
      .in       (in),
      .is_digit (is_digit),
      .is_plus  (is_plus),
      .is_mul   (is_mul),
      .digit    (digit)
   );

   assign digit_w = {{(WIDTH-4){1'b0}}, digit};

`ifdef EXPR_EVAL_OVF_EN
   logic [WIDTH:0]   sum_w;
   logic [WIDTH+3:0] prod_w;
   logic [WIDTH:0]   value_w;

   // Widened datapath so the lost carry/product bits can raise ovf.
   always_comb begin
      sum_w       = {1'b0, sum} + {1'b0, term};
      prod_w      = {4'b0000, term} * {{WIDTH{1'b0}}, digit};
      value_w     = {1'b0, nxt_sum} + {1'b0, nxt_term};
      sum_add     = sum_w[WIDTH-1:0];
      sum_carry   = sum_w[WIDTH];
      prod        = prod_w[WIDTH-1:0];
      prod_carry  = |prod_w[WIDTH+3:WIDTH];
      value_nxt   = value_w[WIDTH-1:0];
      value_carry = value_w[WIDTH];
   end
`else
   // Plain wrapping datapath; overflow is not tracked in this build.
   always_comb begin
      sum_add     = sum + term;
      prod        = term * digit_w;
      value_nxt   = nxt_sum + nxt_term;
      sum_carry   = 1'b0;
      prod_carry  = 1'b0;
      value_carry = 1'b0;
   end
`endif

   // Next-state and next-register decode for one accepted character.
   always_comb begin
      nxt_state  = state;
      nxt_sum    = sum;
      nxt_term   = term;
      nxt_op     = last_op;
      load_value = 1'b0;
      ovf_set    = 1'b0;
      case (state)
         S_START: begin
            if (is_digit) begin
               nxt_term   = digit_w;
               nxt_sum    = '0;
               nxt_state  = S_NUM;
               load_value = 1'b1;
            end else begin
               nxt_state = S_ERR;
            end
         end
         S_NUM: begin
            if (is_plus) begin
               nxt_sum   = sum_add;
               nxt_op    = OP_ADD;
               nxt_state = S_OP;
               ovf_set   = sum_carry;
            end else if (is_mul) begin
               nxt_op    = OP_MUL;
               nxt_state = S_OP;
            end else begin
               nxt_state = S_ERR;
            end
         end
         S_OP: begin
            if (is_digit) begin
               if (last_op == OP_MUL) begin
                  nxt_term = prod;
                  ovf_set  = prod_carry;
               end else begin
                  nxt_term = digit_w;
               end
               nxt_state  = S_NUM;
               load_value = 1'b1;
            end else begin
               nxt_state = S_ERR;
            end
         end
         default: nxt_state = S_ERR;
      endcase
      // The value update itself can carry out (sum + new term).
      if (load_value && value_carry) begin
         ovf_set = 1'b1;
      end
   end

   // Parser state, arithmetic registers and registered outputs.
   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= S_START;
         sum     <= '0;
         term    <= '0;
         last_op <= OP_ADD;
         value   <= '0;
         ok      <= 1'b0;
         err     <= 1'b0;
         ovf     <= 1'b0;
      end else if (in_valid) begin
         state   <= nxt_state;
         sum     <= nxt_sum;
         term    <= nxt_term;
         last_op <= nxt_op;
         ok      <= (nxt_state == S_NUM);
         err     <= (nxt_state == S_ERR);
         if (load_value) begin
            value <= value_nxt;
         end
         if (ovf_set) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_expr_eval.sv
// Directed testbench for expr_eval at WIDTH=8. Expected ovf depends on
// whether EXPR_EVAL_OVF_EN is defined for the build.
module tb_expr_eval;

   localparam int W = 8;

   logic         clk;
   logic         clr;
   logic [7:0]   in;
   logic         in_valid;
   logic [W-1:0] value;
   logic         ok;
   logic         err;
   logic         ovf;

   int n_cmp;
   int n_bad;

`ifdef EXPR_EVAL_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   expr_eval #(.WIDTH(W)) dut (
      .clk      (clk),
      .clr      (clr),
      .in       (in),
      .in_valid (in_valid),
      .value    (value),
      .ok       (ok),
      .err      (err),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send(input logic [7:0] ch);
      in       = ch;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      do_clr();
      n_cmp++;
      if ({value, ok, err, ovf} !== {8'd0, 3'b000}) begin
         n_bad++;
         $display("FAIL reset: value=%0d ok=%b err=%b ovf=%b, required 0 0 0 0",
                  value, ok, err, ovf);
      end
   endtask

   task automatic test_precedence();
      string s;
      logic [W-1:0] ev [5];
      logic         eo [5];
      s = "1+2*3";
      ev = '{8'd1, 8'd1, 8'd3, 8'd3, 8'd7};
      eo = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      do_clr();
      for (int i = 0; i < 5; i++) begin
         send(s[i]);
         n_cmp++;
         if (value !== ev[i] || ok !== eo[i] || err !== 1'b0) begin
            n_bad++;
            $display("FAIL precedence step %0d: value=%0d ok=%b err=%b, required %0d %b 0",
                     i, value, ok, err, ev[i], eo[i]);
         end
      end
   endtask

   task automatic test_mixed();
      string s;
      s = "2*3+4*5";
      do_clr();
      for (int i = 0; i < 4; i++) send(s[i]);
      n_cmp++;
      if (value !== 8'd6 || ok !== 1'b0) begin
         n_bad++;
         $display("FAIL mixed_prefix: value=%0d ok=%b, required 6 0", value, ok);
      end
      for (int i = 4; i < 7; i++) send(s[i]);
      n_cmp++;
      if (value !== 8'd26 || ok !== 1'b1 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL mixed_final: value=%0d ok=%b err=%b, required 26 1 0", value, ok, err);
      end
   endtask

   task automatic test_syntax_error();
      do_clr();
      send("1");
      send("+");
      send("+");
      n_cmp++;
      if (err !== 1'b1 || ok !== 1'b0 || value !== 8'd1) begin
         n_bad++;
         $display("FAIL syntax_err: err=%b ok=%b value=%0d, required 1 0 1", err, ok, value);
      end
      send("2");
      n_cmp++;
      if (err !== 1'b1 || ok !== 1'b0 || value !== 8'd1) begin
         n_bad++;
         $display("FAIL err_sticky: err=%b ok=%b value=%0d, required 1 0 1", err, ok, value);
      end
      in = "5";
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (err !== 1'b1 || value !== 8'd1) begin
         n_bad++;
         $display("FAIL err_stall: err=%b value=%0d, required 1 1", err, value);
      end
   endtask

   task automatic test_illegal();
      do_clr();
      send("a");
      n_cmp++;
      if (err !== 1'b1 || ok !== 1'b0 || value !== 8'd0) begin
         n_bad++;
         $display("FAIL illegal_char: err=%b ok=%b value=%0d, required 1 0 0", err, ok, value);
      end
      do_clr();
      send("*");
      n_cmp++;
      if (err !== 1'b1 || ok !== 1'b0) begin
         n_bad++;
         $display("FAIL leading_op: err=%b ok=%b, required 1 0", err, ok);
      end
      do_clr();
      send("7");
      send("8");
      n_cmp++;
      if (err !== 1'b1 || value !== 8'd7) begin
         n_bad++;
         $display("FAIL digit_digit: err=%b value=%0d, required 1 7", err, value);
      end
   endtask

   task automatic test_overflow();
      string s;
      s = "9*9*9";
      do_clr();
      for (int i = 0; i < 5; i++) send(s[i]);
      n_cmp++;
      if (value !== 8'd217 || ok !== 1'b1 || ovf !== OVF_ON) begin
         n_bad++;
         $display("FAIL ovf_mul: value=%0d ok=%b ovf=%b, required 217 1 %b",
                  value, ok, ovf, OVF_ON);
      end
      s = "9*9";
      do_clr();
      for (int i = 0; i < 3; i++) send(s[i]);
      n_cmp++;
      if (value !== 8'd81 || ok !== 1'b1 || ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL no_ovf: value=%0d ok=%b ovf=%b, required 81 1 0", value, ok, ovf);
      end
      // 243 + 9*9*3: value wraps through 252, 324->68, 486->230
      s = "9*9*3+9*9*3";
      do_clr();
      for (int i = 0; i < 7; i++) send(s[i]);
      n_cmp++;
      if (value !== 8'd252 || ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL add_no_ovf: value=%0d ovf=%b, required 252 0", value, ovf);
      end
      for (int i = 7; i < 11; i++) send(s[i]);
      n_cmp++;
      if (value !== 8'd230 || ok !== 1'b1 || ovf !== OVF_ON) begin
         n_bad++;
         $display("FAIL ovf_value: value=%0d ok=%b ovf=%b, required 230 1 %b",
                  value, ok, ovf, OVF_ON);
      end
   endtask

   task automatic test_stall();
      do_clr();
      send("4");
      in = "+";
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (value !== 8'd4 || ok !== 1'b1) begin
            n_bad++;
            $display("FAIL stall cycle %0d: value=%0d ok=%b, required 4 1", i, value, ok);
         end
      end
      send("+");
      send("5");
      n_cmp++;
      if (value !== 8'd9 || ok !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_final: value=%0d ok=%b, required 9 1", value, ok);
      end
   endtask

   task automatic test_clr_mid();
      do_clr();
      send("5");
      send("*");
      clr      = 1'b1;
      in       = "7";
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if ({value, ok, err, ovf} !== {8'd0, 3'b000}) begin
         n_bad++;
         $display("FAIL clr_mid: value=%0d ok=%b err=%b ovf=%b, required 0 0 0 0",
                  value, ok, err, ovf);
      end
      send("3");
      n_cmp++;
      if (value !== 8'd3 || ok !== 1'b1 || err !== 1'b0 || ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_restart: value=%0d ok=%b err=%b ovf=%b, required 3 1 0 0",
                  value, ok, err, ovf);
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      clr      = 1'b0;
      in       = 8'h00;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_precedence();
      test_mixed();
      test_syntax_error();
      test_illegal();
      test_overflow();
      test_stall();
      test_clr_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
